// File: rtl/fifo_ser_tx.sv
// Serial transmitter that drains a FIFO one word at a time.
// Each word goes out as a start bit, WIDTH data bits LSB first, and a stop bit.
module fifo_ser_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             dequeue,
  output logic             txd,
  output logic             busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             txd_n;
  logic             bit_last;

  assign bit_last = (cnt == CNT_LAST);

  // A pop can only happen when a new frame may begin, so one word per frame.
  assign dequeue = rst && en && !empty &&
                   ((state == IDLE) || ((state == STOP) && bit_last));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = bit_last ? '0 : cnt + CNT_W'(1);
    idx_n   = idx;
    shreg_n = shreg;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (dequeue) begin
          shreg_n = fifo_dout;
          state_n = START;
        end
      end
      START: begin
        if (bit_last) state_n = DATA;
      end
      DATA: begin
        if (bit_last) begin
          shreg_n = shreg >> 1;
          if (idx == IDX_LAST) begin
            idx_n   = '0;
            state_n = STOP;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_last) begin
          if (dequeue) begin
            shreg_n = fifo_dout;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is derived from the next state so txd is a clean register output.
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shreg_n[0];
      default: txd_n = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      txd   <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      txd   <= txd_n;
      busy  <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_fifo_ser_tx.sv
// Directed bench for fifo_ser_tx with a queue-based FIFO model and
// hand-computed frame bit patterns (bit j of a pattern = line level in bit-time j).
module tb_fifo_ser_tx;
  localparam int WIDTH = 8;
  localparam int CPB   = 4;
  localparam int FRAME = (WIDTH + 2) * CPB;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en  = 1'b0;
  logic             empty = 1'b1;
  logic [WIDTH-1:0] fifo_dout = '0;
  logic             dequeue, txd, busy;

  logic [7:0] q[$];
  int checks = 0;
  int errors = 0;
  logic s_deq, s_txd, s_busy;

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;
  } vec_t;
  vec_t vecs[4];

  fifo_ser_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .empty     (empty),
    .fifo_dout (fifo_dout),
    .dequeue   (dequeue),
    .txd       (txd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic step();
    empty     = (q.size() == 0);
    fifo_dout = (q.size() != 0) ? q[0] : 8'h00;
    #1;
    s_deq  = dequeue;
    s_txd  = txd;
    s_busy = busy;
    @(posedge clk);
    if (s_deq) void'(q.pop_front());
    @(negedge clk);
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      step();
      check($sformatf("%s deq c%0d", tag, c), 32'(s_deq), 32'(0));
      check($sformatf("%s txd c%0d", tag, c), 32'(s_txd), 32'(1));
      check($sformatf("%s busy c%0d", tag, c), 32'(s_busy), 32'(0));
    end
  endtask

  task automatic deq_cycle(input string tag);
    step();
    check($sformatf("%s deq", tag), 32'(s_deq), 32'(1));
  endtask

  task automatic frame(input string tag, input logic [9:0] bits, input int n_cyc,
                       input logic chain, input int en_off_at);
    for (int c = 0; c < n_cyc; c++) begin
      if (c == en_off_at) en = 1'b0;
      step();
      check($sformatf("%s txd c%0d", tag, c), 32'(s_txd), 32'(bits[c / CPB]));
      check($sformatf("%s busy c%0d", tag, c), 32'(s_busy), 32'(1));
      check($sformatf("%s deq c%0d", tag, c), 32'(s_deq),
            32'((c == FRAME - 1) && chain));
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'h5A, 10'b1010110100};
    vecs[3] = '{8'hFF, 10'b1111111110};

    // Reset held with a word waiting and en high: nothing may move.
    rst = 1'b0;
    en  = 1'b1;
    q.push_back(vecs[0].data);
    @(negedge clk);
    idle_check("reset", 5);
    rst = 1'b1;

    // Single frames, each followed by a return to idle.
    for (int i = 0; i < 4; i++) begin
      if (i > 0) q.push_back(vecs[i].data);
      deq_cycle($sformatf("single%0d", i));
      check($sformatf("single%0d busy_k", i), 32'(s_busy), 32'(0));
      frame($sformatf("single%0d", i), vecs[i].bits, FRAME, 1'b0, -1);
      idle_check($sformatf("single%0d post", i), 1);
    end

    // Back-to-back frames with zero gap.
    q.push_back(8'h01);
    q.push_back(8'hFF);
    q.push_back(8'h80);
    deq_cycle("b2b");
    frame("b2b_01", 10'b1000000010, FRAME, 1'b1, -1);
    frame("b2b_ff", 10'b1111111110, FRAME, 1'b1, -1);
    frame("b2b_80", 10'b1100000000, FRAME, 1'b0, -1);
    check("b2b fifo_left", 32'(q.size()), 32'(0));
    idle_check("b2b post", 2);

    // en dropped mid-frame: frame finishes, queued word waits.
    q.push_back(8'h3C);
    q.push_back(8'h55);
    deq_cycle("en_off");
    frame("en_3c", 10'b1001111000, FRAME, 1'b0, 9);
    idle_check("en_off hold", 20);
    check("en_off fifo_left", 32'(q.size()), 32'(1));
    en = 1'b1;
    deq_cycle("en_on");
    frame("en_55", 10'b1010101010, FRAME, 1'b0, -1);
    idle_check("en_on post", 1);

    // Reset in data bit 3 of 0x0F; popped word is dropped, 0x42 follows.
    q.push_back(8'h0F);
    q.push_back(8'h42);
    deq_cycle("rst_mid");
    frame("rst_0f", 10'b1000011110, 17, 1'b0, -1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid txd_now", 32'(txd), 32'(1));
    check("rst_mid busy_now", 32'(busy), 32'(0));
    check("rst_mid deq_now", 32'(dequeue), 32'(0));
    @(negedge clk);
    idle_check("rst_mid hold", 3);
    rst = 1'b1;
    deq_cycle("rst_rel");
    frame("rst_42", 10'b1010000100, FRAME, 1'b0, -1);
    check("rst_rel fifo_left", 32'(q.size()), 32'(0));
    idle_check("rst_rel post", 1);

    // Enabled but empty: line stays idle.
    idle_check("empty", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
